// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths, reset PC and the fetch queue entry type.
package cpu_pkg;
    localparam int WIDTH = 16;
    localparam int INSTRUCTIONWIDTH = 24;
    localparam logic [WIDTH-1:0] RESETPC = '0;
    typedef struct packed {
        logic [INSTRUCTIONWIDTH-1:0] instruction;
        logic [WIDTH-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of fetch entries with clear; the head entry is always visible.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic clear,
    input  fetch_entry_t pushEntry,
    output logic [CW-1:0] count,
    output fetch_entry_t headEntry,
    output logic empty
);
    fetch_entry_t storage [DEPTH];
    logic [PW-1:0] headPtr, tailPtr;
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            headPtr <= '0;
            tailPtr <= '0;
            count <= '0;
        end else begin
            if (push) tailPtr <= tailPtr + 1'b1;
            if (pop) headPtr <= headPtr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clock) if (push) storage[tailPtr] <= pushEntry;
    assign headEntry = storage[headPtr];
    assign empty = count == '0;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch into a prefetch FIFO with stall and branch redirect.
// Define FETCHQ_STATS_EN to add saturating stall-cycle and flush counters.
module fetch_queue #(
    parameter int WIDTH = cpu_pkg::WIDTH,
    parameter int INSTRUCTIONWIDTH = cpu_pkg::INSTRUCTIONWIDTH,
    parameter int DEPTH = 4,
    parameter int PCSTEP = 1,
    parameter logic [WIDTH-1:0] RESETPC = cpu_pkg::RESETPC
) (
    input  logic clock,
    input  logic reset,
    input  logic stallD,
    input  logic takeBranchE,
    input  logic [WIDTH-1:0] branchTargetE,
    output logic imemReadEnable,
    output logic [WIDTH-1:0] imemAddress,
    input  logic [INSTRUCTIONWIDTH-1:0] imemReadData,
    output logic validD,
    output logic [INSTRUCTIONWIDTH-1:0] InstructionD,
    output logic [WIDTH-1:0] PCD
`ifdef FETCHQ_STATS_EN
    ,
    output logic [15:0] statStallCycles,
    output logic [15:0] statFlushes
`endif
);
    import cpu_pkg::*;
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] fetchPC, lastAddr;
    logic inflight, deq, push, empty;
    logic [CW-1:0] count;
    fetch_entry_t headEntry, pushEntry;
    assign validD = !empty;
    assign deq = validD && !stallD && !takeBranchE;
    assign push = inflight && !takeBranchE;
    // The response still on its way back already owns a slot, so it is counted as occupancy.
    assign imemReadEnable = !reset && !takeBranchE && (int'(count) + int'(inflight) - int'(deq) < DEPTH);
    assign imemAddress = fetchPC;
    assign pushEntry = {imemReadData, lastAddr};
    assign InstructionD = validD ? headEntry.instruction : '0;
    assign PCD = validD ? headEntry.pc : '0;
    always_ff @(posedge clock) begin
        if (reset) begin
            fetchPC <= RESETPC;
            inflight <= 1'b0;
        end else begin
            inflight <= imemReadEnable;
            fetchPC <= takeBranchE ? branchTargetE : imemReadEnable ? fetchPC + WIDTH'(PCSTEP) : fetchPC;
        end
    end
    always_ff @(posedge clock) if (imemReadEnable) lastAddr <= fetchPC;
    fetch_fifo #(.DEPTH(DEPTH)) queue (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(deq),
        .clear(takeBranchE),
        .pushEntry(pushEntry),
        .count(count),
        .headEntry(headEntry),
        .empty(empty)
    );
`ifdef FETCHQ_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            statStallCycles <= '0;
            statFlushes <= '0;
        end else begin
            if (validD && stallD && statStallCycles != '1) statStallCycles <= statStallCycles + 1'b1;
            if (takeBranchE && statFlushes != '1) statFlushes <= statFlushes + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: vector tables, corner sequences and a randomized run against a queue-based reference model.
module tb_fetch_queue;
    import cpu_pkg::*;
    localparam int DEPTH = 4;
    logic clock = 1'b0, reset = 1'b1, stallD = 1'b0, takeBranchE = 1'b0;
    logic [15:0] branchTargetE = '0;
    logic imemReadEnable, validD;
    logic [15:0] imemAddress, PCD;
    logic [23:0] imemReadData = '0, InstructionD;
`ifdef FETCHQ_STATS_EN
    logic [15:0] statStallCycles, statFlushes;
`endif
    int nChecks = 0, nFail = 0;
    always #5 clock = ~clock;
    fetch_queue dut (
        .clock(clock),
        .reset(reset),
        .stallD(stallD),
        .takeBranchE(takeBranchE),
        .branchTargetE(branchTargetE),
        .imemReadEnable(imemReadEnable),
        .imemAddress(imemAddress),
        .imemReadData(imemReadData),
        .validD(validD),
        .InstructionD(InstructionD),
        .PCD(PCD)
`ifdef FETCHQ_STATS_EN
        ,
        .statStallCycles(statStallCycles),
        .statFlushes(statFlushes)
`endif
    );
    function automatic logic [23:0] memWord(input logic [15:0] a);
        return 24'h100000 + {8'h00, a};
    endfunction
    // Synchronous-read instruction memory.
    always @(posedge clock) if (imemReadEnable) imemReadData <= memWord(imemAddress);
    always @(negedge clock)
        if (!reset && dut.queue.push && !dut.queue.pop && dut.queue.count == 3'(DEPTH)) begin
            nFail++;
            $display("FAIL fifoOverflow at %0t: push into full queue (count %0d)", $time, dut.queue.count);
        end
    // Reference model: the queue contents, the one outstanding request and the next fetch address.
    typedef struct packed { logic [15:0] pc; logic [23:0] ins; } ment_t;
    ment_t mq[$];
    bit mPend;
    logic [15:0] mPendAddr, mPc;
    int mStall, mFlush;
    typedef struct { logic st; logic br; logic [15:0] tg; logic re; logic [15:0] a; logic v; logic [15:0] pc; } vec_t;
    vec_t vecs[$];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask
    task automatic drive(input logic st, input logic br, input logic [15:0] tg, input logic rs);
        stallD = st;
        takeBranchE = br;
        branchTargetE = tg;
        reset = rs;
        #2;
    endtask
    task automatic modelStep();
        bit pop, iss;
        int occ;
        pop = mq.size() > 0 && !stallD && !takeBranchE;
        occ = mq.size() + int'(mPend) - int'(pop);
        iss = !reset && !takeBranchE && occ < DEPTH;
        chk("imemReadEnable", imemReadEnable, iss);
        chk("imemAddress", imemAddress, mPc);
        chk("validD", validD, mq.size() > 0);
        chk("PCD", PCD, mq.size() > 0 ? mq[0].pc : 16'h0);
        chk("InstructionD", InstructionD, mq.size() > 0 ? mq[0].ins : 24'h0);
`ifdef FETCHQ_STATS_EN
        chk("statStallCycles", statStallCycles, mStall);
        chk("statFlushes", statFlushes, mFlush);
`endif
        if (reset) begin
            mq.delete();
            mPend = 0;
            mPc = RESETPC;
            mStall = 0;
            mFlush = 0;
        end else begin
            if (mq.size() > 0 && stallD && mStall < 65535) mStall++;
            if (takeBranchE) begin
                mq.delete();
                mPend = 0;
                mPc = branchTargetE;
                if (mFlush < 65535) mFlush++;
            end else begin
                if (pop) void'(mq.pop_front());
                if (mPend) mq.push_back({mPendAddr, memWord(mPendAddr)});
                mPend = iss;
                if (iss) begin
                    mPendAddr = mPc;
                    mPc = mPc + 16'd1;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask
    task automatic step(input logic st, input logic br, input logic [15:0] tg, input logic rs);
        drive(st, br, tg, rs);
        modelStep();
    endtask
    task automatic doReset(input int n);
        repeat (n) step(1'b0, 1'b0, 16'h0, 1'b1);
    endtask
    task automatic addVec(input logic st, input logic br, input logic [15:0] tg, input logic re,
                          input logic [15:0] a, input logic v, input logic [15:0] pc);
        vecs.push_back('{st, br, tg, re, a, v, pc});
    endtask
    task automatic runVecs(input string tag);
        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].br, vecs[i].tg, 1'b0);
            chk($sformatf("%s[%0d].re", tag, i), imemReadEnable, vecs[i].re);
            chk($sformatf("%s[%0d].addr", tag, i), imemAddress, vecs[i].a);
            chk($sformatf("%s[%0d].validD", tag, i), validD, vecs[i].v);
            chk($sformatf("%s[%0d].PCD", tag, i), PCD, vecs[i].pc);
            if (vecs[i].v) chk($sformatf("%s[%0d].instr", tag, i), InstructionD, memWord(vecs[i].pc));
            if (tag == "stall" && i == 8) chk("stallFullCount", dut.queue.count, DEPTH);
            modelStep();
        end
        vecs.delete();
    endtask
    initial begin
        int burst = 0;
        repeat (2) @(posedge clock);
        #1;
        mq.delete();
        mPend = 0;
        mPc = RESETPC;
        mStall = 0;
        mFlush = 0;
        doReset(2);
        // Startup, streaming and a branch in cycle 6 to 0x0040.
        addVec(0, 0, 16'h0, 1, 16'h0000, 0, 16'h0000);
        addVec(0, 0, 16'h0, 1, 16'h0001, 0, 16'h0000);
        for (int c = 2; c < 6; c++) addVec(0, 0, 16'h0, 1, 16'(c), 1, 16'(c - 2));
        addVec(0, 1, 16'h0040, 0, 16'h0006, 1, 16'h0004);
        addVec(0, 0, 16'h0, 1, 16'h0040, 0, 16'h0000);
        addVec(0, 0, 16'h0, 1, 16'h0041, 0, 16'h0000);
        addVec(0, 0, 16'h0, 1, 16'h0042, 1, 16'h0040);
        addVec(0, 0, 16'h0, 1, 16'h0043, 1, 16'h0041);
        runVecs("branch");
        // Stall from cycle 3 for 10 cycles.
        doReset(2);
        addVec(0, 0, 16'h0, 1, 16'h0000, 0, 16'h0000);
        addVec(0, 0, 16'h0, 1, 16'h0001, 0, 16'h0000);
        addVec(0, 0, 16'h0, 1, 16'h0002, 1, 16'h0000);
        addVec(1, 0, 16'h0, 1, 16'h0003, 1, 16'h0001);
        addVec(1, 0, 16'h0, 1, 16'h0004, 1, 16'h0001);
        for (int c = 5; c < 13; c++) addVec(1, 0, 16'h0, 0, 16'h0005, 1, 16'h0001);
        addVec(0, 0, 16'h0, 1, 16'h0005, 1, 16'h0001);
        for (int c = 14; c < 18; c++) addVec(0, 0, 16'h0, 1, 16'(c - 8), 1, 16'(c - 12));
        runVecs("stall");
        // Flush together with stall on a full queue.
        doReset(2);
        repeat (10) step(1'b1, 1'b0, 16'h0, 1'b0);
        drive(1'b1, 1'b1, 16'h0200, 1'b0);
        chk("fullBeforeFlush.validD", validD, 1'b1);
        chk("fullBeforeFlush.count", dut.queue.count, DEPTH);
        modelStep();
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        chk("afterFlush.validD", validD, 1'b0);
        chk("afterFlush.re", imemReadEnable, 1'b1);
        chk("afterFlush.addr", imemAddress, 16'h0200);
        modelStep();
        step(1'b0, 1'b0, 16'h0, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        chk("flushTarget.PCD", PCD, 16'h0200);
        modelStep();
        // PC wrap from 0xFFFF to 0x0000.
        doReset(2);
        step(1'b0, 1'b1, 16'hFFFE, 1'b0);
        repeat (2) step(1'b0, 1'b0, 16'h0, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        chk("wrap.PCD0", PCD, 16'hFFFE);
        modelStep();
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        chk("wrap.PCD1", PCD, 16'hFFFF);
        modelStep();
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        chk("wrap.PCD2", PCD, 16'h0000);
        chk("wrap.instr", InstructionD, 24'h100000);
        modelStep();
        // Reset with three entries queued and one request in flight.
        doReset(2);
        repeat (3) step(1'b0, 1'b0, 16'h0, 1'b0);
        repeat (2) step(1'b1, 1'b0, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 1'b1);
        chk("midReset.count", dut.queue.count, 3);
        chk("midReset.re", imemReadEnable, 1'b0);
        modelStep();
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        chk("postReset.validD", validD, 1'b0);
        chk("postReset.addr", imemAddress, RESETPC);
`ifdef FETCHQ_STATS_EN
        chk("postReset.statStall", statStallCycles, 0);
        chk("postReset.statFlush", statFlushes, 0);
`endif
        modelStep();
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        chk("postReset.noStale", validD, 1'b0);
        modelStep();
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        chk("postReset.PCD", PCD, RESETPC);
        chk("postReset.instr", InstructionD, memWord(RESETPC));
        modelStep();
        // Randomized traffic with stall bursts, branches near the wrap point and occasional resets.
        doReset(2);
        for (int n = 0; n < 1500; n++) begin
            logic st, br, rs;
            logic [15:0] tg;
            if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(3, 8);
            st = burst > 0 || $urandom_range(0, 99) < 25;
            if (burst > 0) burst--;
            br = $urandom_range(0, 99) < 6;
            tg = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
            rs = $urandom_range(0, 199) == 0;
            step(st, br, tg, rs);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage with a small prefetch queue, sitting between the instruction memory port and the Fetch/Decode pipeline boundary. It generates sequential instruction addresses and captures synchronous-read memory responses into a DEPTH-entry FIFO. It presents one `{instruction, PC}` pair per cycle to Decode, honours the hazard unit's stall, and redirects on a taken branch by discarding all queued and in-flight fetches.

## Interface
- `WIDTH`, 16: PC/address width.
- `INSTRUCTIONWIDTH`, 24: instruction word width.
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `PCSTEP`, 1: sequential PC increment (word addressing).
- `RESETPC`, 0: first fetch address after reset.

Ports:
- `clock`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `stallD`  in  1: Decode cannot accept this cycle (hazard unit).
- `takeBranchE`  in  1: taken branch; flush and redirect.
- `branchTargetE`  in  WIDTH: redirect address, valid with `takeBranchE`.
- `imemReadEnable`  out  1: read request this cycle.
- `imemAddress`  out  WIDTH: read address.
- `imemReadData`  in  INSTRUCTIONWIDTH: data for the previous cycle's request.
- `validD`  out  1: head entry valid.
- `InstructionD`  out  INSTRUCTIONWIDTH: head instruction.
- `PCD`  out  WIDTH: head PC.

## Operation
- State:
  - `fetchPC` register.
  - `inflight` bit: a request was issued last cycle.
  - FIFO storage with head/tail pointers and `count` of width clog2(DEPTH+1).
- Pop: `deq = validD && !stallD && !takeBranchE`. The head advances.
- Issue: `imemReadEnable = !reset && !takeBranchE && (count + inflight - deq) < DEPTH`. `imemAddress = fetchPC`. On issue, `fetchPC <= fetchPC + PCSTEP`; wrap is modulo 2^WIDTH.
- Response: when `inflight` is 1 and `takeBranchE` is 0, push `{imemReadData, address}` at the tail. The address comes from a one-deep register of the last issued address.
- Credit rule: a push never finds the FIFO full. Overflow is a design error; the bench asserts against it.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Flush (`takeBranchE=1`):
  - `count <= 0`; pointers reset.
  - The response arriving this cycle is dropped.
  - No issue this cycle.
  - `fetchPC <= branchTargetE`.
  - Flush has priority over `stallD` and over push/pop.
- Outputs `validD`, `InstructionD` and `PCD` come from the head entry and registered `count`. No combinational path exists from `imemReadData` or `stallD` to them.
- Reset values:
  - `fetchPC = RESETPC`.
  - `count = 0`, `inflight = 0`.
  - `validD = 0`, `InstructionD = 0`, `PCD = 0`.
  - `imemReadEnable = 0` while `reset` is high.
- Reset mid-operation discards all entries and any in-flight response.

## Timing
- Startup: reset deasserted before edge 0.
  - Cycle 0: issue `RESETPC`.
  - Cycle 1: data returns and is pushed.
  - Cycle 2: `validD=1`, `PCD=RESETPC`.
- Fetch-to-Decode latency is 2 cycles. Steady-state throughput is 1 instruction/cycle with no stalls.
- Branch penalty: flush in cycle N, issue target in N+1, push in N+2, `validD` with `PCD=target` in N+3.
- Stall: issue continues until `count + inflight == DEPTH`, then `imemReadEnable=0`. Issue resumes in the first cycle a pop is granted.

## Configuration
- `FETCHQ_STATS_EN` defined: adds two 16-bit saturating counters, cleared by reset:
  - `statStallCycles`: counts cycles with `validD && stallD`.
  - `statFlushes`: counts `takeBranchE` cycles.
  - Both drive output ports of the same names.
- Not defined: the counters and their ports are absent. Functional behaviour is identical either way.

## Structure
- Shared package `cpu_pkg`:
  - `WIDTH` and `INSTRUCTIONWIDTH` constants.
  - A packed typedef `fetch_entry_t {instruction, pc}`.
  - `RESETPC`.
- One sub-module, `fetch_fifo`:
  - Parameterised storage of `fetch_entry_t`.
  - Push, pop and clear inputs.
  - `count`, head entry and empty outputs.
- Issue, credit and redirect logic stay in `fetch_queue`.

## Test plan
- Reset release, no stall, memory returns `addr+0x100000` → `PCD` = 0,1,2,3… from cycle 2, one per cycle. `InstructionD` matches; `validD` is never low after cycle 2.
- Hold `stallD=1` from cycle 3 for 10 cycles → `count` reaches 4 and `imemReadEnable` drops. Head stays `PCD=1`. After release, `PCD` = 2,3,4,5… with no gap or duplicate.
- `takeBranchE=1`, `branchTargetE=0x0040` in cycle 6 → the response in cycle 6 is dropped and `imemAddress=0x0040` in cycle 7. `validD=0` in cycles 7–8; `PCD=0x0040` in cycle 9, then 0x0041.
- `takeBranchE` and `stallD` both high with a full queue → flush wins: queue empty next cycle, redirect taken, no pop counted.
- `fetchPC=0xFFFF` sequential → the next `PCD` after 0xFFFF is 0x0000.
- `reset` asserted for 1 cycle with 3 entries queued and one request in flight → `validD=0`. Fetch restarts at `RESETPC`; the stale response never appears. With `FETCHQ_STATS_EN`, both counters read 0.
